// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: money width, coin denominations,
// one-hot coin encodings and the change-dispenser state encoding.
package vm_pkg;

    localparam int MONEY_W = 7;

    localparam logic [MONEY_W-1:0] DEN_50 = 7'd50;
    localparam logic [MONEY_W-1:0] DEN_20 = 7'd20;
    localparam logic [MONEY_W-1:0] DEN_10 = 7'd10;
    localparam logic [MONEY_W-1:0] DEN_5  = 7'd5;

    // Bit order matches the hopper interface: bit3=50 ... bit0=5.
    localparam logic [3:0] COIN_50   = 4'b1000;
    localparam logic [3:0] COIN_20   = 4'b0100;
    localparam logic [3:0] COIN_10   = 4'b0010;
    localparam logic [3:0] COIN_5    = 4'b0001;
    localparam logic [3:0] COIN_NONE = 4'b0000;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SELECT   = 2'd1;
    localparam logic [1:0] ST_DISPENSE = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

endpackage

// File: rtl/coin_picker.sv
// Greedy coin choice: the largest denomination that fits in the remaining
// amount and still has stock in the hopper.
module coin_picker
    import vm_pkg::*;
(
    input  logic [MONEY_W-1:0] remaining_i,
    input  logic [3:0]         in_stock_i,
    output logic [3:0]         coin_o,
    output logic [MONEY_W-1:0] value_o,
    output logic               found_o
);

    always_comb begin
        coin_o  = COIN_NONE;
        value_o = '0;
        found_o = 1'b0;
        if (in_stock_i[3] && remaining_i >= DEN_50) begin
            coin_o  = COIN_50;
            value_o = DEN_50;
            found_o = 1'b1;
        end else if (in_stock_i[2] && remaining_i >= DEN_20) begin
            coin_o  = COIN_20;
            value_o = DEN_20;
            found_o = 1'b1;
        end else if (in_stock_i[1] && remaining_i >= DEN_10) begin
            coin_o  = COIN_10;
            value_o = DEN_10;
            found_o = 1'b1;
        end else if (in_stock_i[0] && remaining_i >= DEN_5) begin
            coin_o  = COIN_5;
            value_o = DEN_5;
            found_o = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount out as single coins over a valid/ack handshake,
// tracking per-denomination hopper stock and reporting any unpaid remainder.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int HOPPER_DEPTH = 15,
    parameter int CNT_W        = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [MONEY_W-1:0] change_in,
    input  logic               change_valid,
    input  logic               refill,
    output logic               coin_valid,
    output logic [3:0]         coin_out,
    input  logic               coin_ack,
    output logic               busy,
    output logic               done,
    output logic [MONEY_W-1:0] shortfall,
    output logic               error,
    output logic [3:0]         hopper_empty
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(HOPPER_DEPTH);

    logic [1:0]                 state_q, state_d;
    logic [MONEY_W-1:0]         remaining_q, remaining_d;
    logic [3:0][CNT_W-1:0]      stock_q, stock_d;
    logic                       coin_valid_q, coin_valid_d;
    logic [3:0]                 coin_out_q, coin_out_d;
    logic [MONEY_W-1:0]         coin_value_q, coin_value_d;
    logic [MONEY_W-1:0]         shortfall_q, shortfall_d;
    logic                       error_q, error_d;

    logic [3:0]                 pick_coin;
    logic [MONEY_W-1:0]         pick_value;
    logic                       pick_found;

    coin_picker u_picker (
        .remaining_i (remaining_q),
        .in_stock_i  (~hopper_empty),
        .coin_o      (pick_coin),
        .value_o     (pick_value),
        .found_o     (pick_found)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hopper_empty[i] = (stock_q[i] == '0);
        end
    end

    always_comb begin
        // NOTE: every next-state signal starts from its current value so no path leaves it unassigned (no latch).
        state_d      = state_q;
        remaining_d  = remaining_q;
        stock_d      = stock_q;
        coin_valid_d = coin_valid_q;
        coin_out_d   = coin_out_q;
        coin_value_d = coin_value_q;
        shortfall_d  = shortfall_q;
        error_d      = error_q;

        case (state_q)
            ST_IDLE: begin
                if (change_valid) begin
                    remaining_d = change_in;
                    shortfall_d = '0;
                    error_d     = 1'b0;
                    state_d     = ST_SELECT;
                end else if (refill) begin
                    stock_d = {4{FULL}};
                end
            end
            ST_SELECT: begin
                if (pick_found) begin
                    coin_out_d   = pick_coin;
                    coin_value_d = pick_value;
                    coin_valid_d = 1'b1;
                    state_d      = ST_DISPENSE;
                end else begin
                    // Latched on entry to DONE so the result is valid alongside done.
                    shortfall_d = remaining_q;
                    error_d     = (remaining_q != '0);
                    state_d     = ST_DONE;
                end
            end
            ST_DISPENSE: begin
                if (coin_ack && coin_valid_q) begin
                    remaining_d = remaining_q - coin_value_q;
                    for (int i = 0; i < 4; i++) begin
                        if (coin_out_q[i]) stock_d[i] = stock_q[i] - CNT_W'(1);
                    end
                    coin_valid_d = 1'b0;
                    coin_out_d   = COIN_NONE;
                    state_d      = ST_SELECT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            // NOTE: the stock counters are ordinary flops, so reset reloads them like any other state.
            stock_q      <= {4{FULL}};
            coin_valid_q <= 1'b0;
            coin_out_q   <= COIN_NONE;
            coin_value_q <= '0;
            shortfall_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            stock_q      <= stock_d;
            coin_valid_q <= coin_valid_d;
            coin_out_q   <= coin_out_d;
            coin_value_q <= coin_value_d;
            shortfall_q  <= shortfall_d;
            error_q      <= error_d;
        end
    end

    assign coin_valid = coin_valid_q;
    assign coin_out   = coin_out_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign shortfall  = shortfall_q;
    assign error      = error_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a default-depth and a depth-1
// instance, table vectors, hand sequences and a randomized run.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] change_in;
    logic       change_valid;
    logic       refill;
    logic       coin_ack;
    logic       sel;

    logic       cv_a, rf_a, ack_a, cv_b, rf_b, ack_b;
    logic       coin_valid_a, busy_a, done_a, error_a;
    logic       coin_valid_b, busy_b, done_b, error_b;
    logic [3:0] coin_out_a, empty_a, coin_out_b, empty_b;
    logic [6:0] shortfall_a, shortfall_b;

    logic       coin_valid_s, busy_s, done_s, error_s;
    logic [3:0] coin_out_s, empty_s;
    logic [6:0] shortfall_s;

    int total = 0;
    int bad   = 0;

    int mdl_stock [2][4];
    int depth     [2] = '{15, 1};
    int den       [4] = '{50, 20, 10, 5};
    int exp_q     [$];

    always #5 clock = ~clock;

    assign cv_a  = change_valid & ~sel;
    assign rf_a  = refill & ~sel;
    assign ack_a = coin_ack & ~sel;
    assign cv_b  = change_valid & sel;
    assign rf_b  = refill & sel;
    assign ack_b = coin_ack & sel;

    assign coin_valid_s = sel ? coin_valid_b : coin_valid_a;
    assign coin_out_s   = sel ? coin_out_b   : coin_out_a;
    assign busy_s       = sel ? busy_b       : busy_a;
    assign done_s       = sel ? done_b       : done_a;
    assign shortfall_s  = sel ? shortfall_b  : shortfall_a;
    assign error_s      = sel ? error_b      : error_a;
    assign empty_s      = sel ? empty_b      : empty_a;

    change_dispenser dut (
        .clock(clock), .reset(reset), .change_in(change_in), .change_valid(cv_a),
        .refill(rf_a), .coin_valid(coin_valid_a), .coin_out(coin_out_a), .coin_ack(ack_a),
        .busy(busy_a), .done(done_a), .shortfall(shortfall_a), .error(error_a),
        .hopper_empty(empty_a)
    );

    change_dispenser #(.HOPPER_DEPTH(1), .CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .change_in(change_in), .change_valid(cv_b),
        .refill(rf_b), .coin_valid(coin_valid_b), .coin_out(coin_out_b), .coin_ack(ack_b),
        .busy(busy_b), .done(done_b), .shortfall(shortfall_b), .error(error_b),
        .hopper_empty(empty_b)
    );

    typedef struct {
        int amt;
        int wait_n;
        int ncoins;
        int short_amt;
        int err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference: greedy by denomination, each limited by remaining stock.
    task automatic model_payout(input int amt, output int short_amt);
        int rem;
        rem = amt;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            while (rem >= den[k] && mdl_stock[sel][k] > 0) begin
                exp_q.push_back(k);
                rem -= den[k];
                mdl_stock[sel][k]--;
            end
        end
        short_amt = rem;
    endtask

    task automatic model_restock(input int which);
        for (int k = 0; k < 4; k++) mdl_stock[which][k] = depth[which];
    endtask

    task automatic do_refill();
        @(negedge clock);
        refill = 1'b1;
        @(negedge clock);
        refill = 1'b0;
        model_restock(int'(sel));
    endtask

    task automatic run_txn(input int amt, input int wait_n, input bit chk_lat,
                           input int inject_at, input bit with_refill, output int n_seen);
        int         exp_short, n_exp, cyc, held;
        bit         saw_done;
        logic [3:0] cur_coin;
        model_payout(amt, exp_short);
        n_exp    = exp_q.size();
        n_seen   = 0;
        held     = 0;
        saw_done = 1'b0;
        cur_coin = 4'b0000;
        @(negedge clock);
        change_in    = 7'(amt);
        change_valid = 1'b1;
        refill       = with_refill;
        coin_ack     = 1'b0;
        @(negedge clock);
        change_valid = 1'b0;
        refill       = 1'b0;
        cyc = 1;
        while (cyc <= 300) begin
            if (done_s) begin
                saw_done = 1'b1;
                break;
            end
            coin_ack     = 1'b0;
            change_valid = 1'b0;
            if (coin_valid_s) begin
                if (held == 0) begin
                    cur_coin = coin_out_s;
                    if (exp_q.size() > 0) begin
                        check("coin_order", coin_out_s, 4'b1000 >> exp_q[0]);
                        void'(exp_q.pop_front());
                    end else begin
                        check("extra_coin", coin_valid_s, 0);
                    end
                end else begin
                    check("coin_stable", coin_out_s, cur_coin);
                end
                held++;
                if (held > wait_n) begin
                    coin_ack = 1'b1;
                    n_seen++;
                    held = 0;
                end
            end else begin
                check("coin_out_zero", coin_out_s, 0);
                if (wait_n > 0) coin_ack = 1'b1;
            end
            if (cyc == inject_at) begin
                change_in    = 7'd50;
                change_valid = 1'b1;
            end
            @(negedge clock);
            cyc++;
        end
        coin_ack     = 1'b0;
        change_valid = 1'b0;
        check("done_seen", saw_done, 1);
        if (chk_lat) check("done_latency", cyc, 2 * n_exp + 2);
        check("coin_count", n_seen, n_exp);
        check("shortfall", shortfall_s, exp_short);
        check("error", error_s, exp_short != 0);
        @(negedge clock);
        check("done_one_cycle", done_s, 0);
        check("idle_after_done", busy_s, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   n_seen;

        vecs[0] = '{amt: 85,  wait_n: 0, ncoins: 4, short_amt: 0, err: 0};
        vecs[1] = '{amt: 37,  wait_n: 0, ncoins: 3, short_amt: 2, err: 1};
        vecs[2] = '{amt: 0,   wait_n: 0, ncoins: 0, short_amt: 0, err: 0};
        vecs[3] = '{amt: 127, wait_n: 0, ncoins: 4, short_amt: 2, err: 1};
        vecs[4] = '{amt: 5,   wait_n: 1, ncoins: 1, short_amt: 0, err: 0};
        vecs[5] = '{amt: 4,   wait_n: 0, ncoins: 0, short_amt: 4, err: 1};
        vecs[6] = '{amt: 100, wait_n: 2, ncoins: 2, short_amt: 0, err: 0};
        vecs[7] = '{amt: 95,  wait_n: 0, ncoins: 4, short_amt: 0, err: 0};
        vecs[8] = '{amt: 123, wait_n: 1, ncoins: 3, short_amt: 3, err: 1};

        sel          = 1'b0;
        reset        = 1'b1;
        change_in    = '0;
        change_valid = 1'b0;
        refill       = 1'b0;
        coin_ack     = 1'b0;
        model_restock(0);
        model_restock(1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("rst_busy", busy_s, 0);
        check("rst_coin_valid", coin_valid_s, 0);
        check("rst_coin_out", coin_out_s, 0);
        check("rst_done", done_s, 0);
        check("rst_shortfall", shortfall_s, 0);
        check("rst_error", error_s, 0);
        check("rst_empty", empty_s, 0);

        // Table vectors, each from a freshly refilled hopper.
        for (int i = 0; i < 9; i++) begin
            do_refill();
            run_txn(vecs[i].amt, vecs[i].wait_n, vecs[i].wait_n == 0, 0, 1'b0, n_seen);
            check("tbl_ncoins", n_seen, vecs[i].ncoins);
            check("tbl_shortfall", shortfall_s, vecs[i].short_amt);
            check("tbl_error", error_s, vecs[i].err);
        end

        // Slow hopper: 60 with three-cycle ack stalls and stray acks.
        do_refill();
        run_txn(60, 3, 1'b0, 0, 1'b0, n_seen);
        check("slow_ncoins", n_seen, 2);

        // change_valid while busy must not start a second payout.
        do_refill();
        run_txn(37, 0, 1'b1, 3, 1'b0, n_seen);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("no_second_busy", busy_s, 0);
            check("no_second_coin", coin_valid_s, 0);
        end

        // Depth-1 hopper: exhaustion, simultaneous strobe+refill, then refill.
        sel = 1'b1;
        run_txn(100, 0, 1'b1, 0, 1'b0, n_seen);
        check("d1_ncoins", n_seen, 4);
        check("d1_shortfall", shortfall_s, 15);
        check("d1_empty", empty_s, 4'b1111);
        run_txn(5, 0, 1'b1, 0, 1'b1, n_seen);
        check("d1_refill_dropped", empty_s, 4'b1111);
        do_refill();
        check("d1_refilled", empty_s, 4'b0000);

        // Reset during the second DISPENSE of a 75 payout on the depth-1 hopper.
        @(negedge clock);
        change_in    = 7'd75;
        change_valid = 1'b1;
        @(negedge clock);
        change_valid = 1'b0;
        coin_ack     = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_mid_coin_valid", coin_valid_s, 1);
        check("rst_mid_coin", coin_out_s, 4'b0100);
        check("rst_mid_empty_before", empty_s, 4'b1000);
        coin_ack = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid_coin_valid_after", coin_valid_s, 0);
        check("rst_mid_busy_after", busy_s, 0);
        check("rst_mid_done_after", done_s, 0);
        check("rst_mid_empty_after", empty_s, 0);
        model_restock(0);
        model_restock(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_mid_no_done", done_s, 0);
        end

        // Randomized payouts on the default hopper, stock carried over.
        sel = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 5) == 0) do_refill();
            run_txn(int'($urandom_range(0, 127)), int'($urandom_range(0, 2)), 1'b0, 0, 1'b0, n_seen);
            for (int k = 0; k < 4; k++) begin
                check("rand_empty", empty_s[3-k], mdl_stock[0][k] == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
